rv_ifetch: RTL and testbench

- Multi-hart instruction fetch stage; sits directly upstream of the instruction decoder and drives its 32-bit instruction input.
- Holds one PC per hart and selects harts round-robin (barrel style).
- Issues one instruction-memory request at a time and presents the returned word with PC/hart tags through a valid/ready handshake.
- Accepts PC redirects (jumps, branches, mret) from execute; a redirect kills any in-flight fetch for that hart.

---
 rtl/rv_ifetch_if.sv | 48 ++++
 rtl/rv_ifetch.sv | 127 ++++++++++++
 tb/tb_rv_ifetch.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_ifetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, decoder-facing output and execute redirect.
// Optional IFETCH_ERR_EN adds imem_err (memory -> fetch) and inst_fault (fetch -> decoder).
interface rv_ifetch_if #(
    parameter int NUM_HARTS = 4,
    parameter int HART_W    = $clog2(NUM_HARTS)
);
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
`ifdef IFETCH_ERR_EN
    logic              imem_err;
    logic              inst_fault;
`endif
    logic              inst_valid;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic [HART_W-1:0] inst_hart;
    logic              inst_ready;
    logic              redirect_valid;
    logic [HART_W-1:0] redirect_hart;
    logic [31:0]       redirect_pc;

`ifdef IFETCH_ERR_EN
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_hart, inst_fault,
        input  imem_gnt, imem_rvalid, imem_rdata, imem_err, inst_ready,
               redirect_valid, redirect_hart, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_hart, inst_fault,
        output imem_gnt, imem_rvalid, imem_rdata, imem_err, inst_ready,
               redirect_valid, redirect_hart, redirect_pc
    );
`else
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_hart,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_hart, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_hart,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_hart, redirect_pc
    );
`endif
endinterface

// File: rtl/rv_ifetch.sv
// Barrel-style multi-hart instruction fetch: one outstanding imem request, round-robin hart pick.
// Optional IFETCH_ERR_EN: error responses deliver inst=0 with inst_fault=1.
//
// state  | meaning
// S_IDLE | pick next enabled hart at/after rr, launch its request
// S_REQ  | imem_req high with stable address until imem_gnt
// S_WAIT | granted, waiting for imem_rvalid (kill drops the response)
// S_HOLD | inst_valid high until inst_ready or a redirect to cur
module rv_ifetch #(
    parameter int          NUM_HARTS = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_HARTS-1:0] hart_en,
    rv_ifetch_if.master          bus
);
    localparam int HART_W = $clog2(NUM_HARTS);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            state;
    logic [31:0]       pc [NUM_HARTS];
    logic [HART_W-1:0] rr;
    logic [HART_W-1:0] cur;
    logic              kill;

    logic [HART_W-1:0] sel;
    logic              sel_found;
    logic [HART_W-1:0] idx;
    logic              redir_cur;
    logic [31:0]       redir_pc;

    assign redir_cur = bus.redirect_valid && (bus.redirect_hart == cur);
    assign redir_pc  = {bus.redirect_pc[31:2], 2'b00};

    // Descending scan so the smallest offset from rr wins; index wraps since NUM_HARTS is 2^n.
    always_comb begin
        sel       = rr;
        sel_found = 1'b0;
        idx       = rr;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            idx = rr + HART_W'(i);
            if (hart_en[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            rr             <= '0;
            cur            <= '0;
            kill           <= 1'b0;
            bus.imem_req   <= 1'b0;
            bus.imem_addr  <= '0;
            bus.inst_valid <= 1'b0;
            bus.inst       <= '0;
            bus.inst_pc    <= '0;
            bus.inst_hart  <= '0;
`ifdef IFETCH_ERR_EN
            bus.inst_fault <= 1'b0;
`endif
            for (int h = 0; h < NUM_HARTS; h++) pc[h] <= RESET_PC;
        end else begin
            // A redirect always beats the +4 of a coincident handshake.
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (bus.redirect_valid && bus.redirect_hart == HART_W'(h))
                    pc[h] <= redir_pc;
                else if (state == S_HOLD && bus.inst_ready && cur == HART_W'(h))
                    pc[h] <= pc[h] + 32'd4;
            end

            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        cur          <= sel;
                        state        <= S_REQ;
                        bus.imem_req <= 1'b1;
                        // Forward a same-cycle redirect so the request already uses the new PC.
                        bus.imem_addr <= (bus.redirect_valid && bus.redirect_hart == sel)
                                         ? redir_pc : pc[sel];
                    end
                end
                S_REQ: begin
                    if (redir_cur) kill <= 1'b1;
                    if (bus.imem_gnt) begin
                        bus.imem_req <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (kill || redir_cur) begin
                            kill  <= 1'b0;
                            rr    <= cur + HART_W'(1);
                            state <= S_IDLE;
                        end else begin
`ifdef IFETCH_ERR_EN
                            bus.inst       <= bus.imem_err ? 32'h0000_0000 : bus.imem_rdata;
                            bus.inst_fault <= bus.imem_err;
`else
                            bus.inst       <= bus.imem_rdata;
`endif
                            bus.inst_pc    <= pc[cur];
                            bus.inst_hart  <= cur;
                            bus.inst_valid <= 1'b1;
                            state          <= S_HOLD;
                        end
                    end else if (redir_cur) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redir_cur || bus.inst_ready) begin
                        bus.inst_valid <= 1'b0;
                        rr             <= cur + HART_W'(1);
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_ifetch.sv
// Self-checking bench for rv_ifetch: transaction-level model of PCs, round-robin pick and kills,
// compared every cycle, plus directed scenarios pinned with literal expectations.
module tb_rv_ifetch;
    localparam int          NH     = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NH-1:0] hart_en = '0;

    rv_ifetch_if #(.NUM_HARTS(NH)) ifc();

    rv_ifetch #(.NUM_HARTS(NH), .RESET_PC(RST_PC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .hart_en (hart_en),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, want %08h at %0t", name, act, exp, $time);
    endtask

    // reference model state
    logic [31:0] mpc [NH];
    int          mrr;
    bit          m_idle;
    bit          txn_act, txn_gnt, txn_kill;
    int          txn_hart;
    logic [31:0] txn_addr;
    bit          hold_act;
    int          hold_hart;
    logic [31:0] hold_pc, hold_inst;
    bit          hold_fault;

    // inputs the DUT saw at the most recent rising edge
    logic [NH-1:0] p_en;
    bit            p_gnt, p_rvalid, p_ready, p_redir, p_err;
    logic [31:0]   p_rdata, p_rpc;
    int            p_rh;
    bit            q_req;

    // stimulus knobs
    logic [NH-1:0] want_en = '0;
    int            ready_mode = 0;
    int            fix_lat = 0;
    bit            rand_redir = 0, rand_en = 0, fixed_data = 1, err_on = 0;
    bit            os_redir = 0, os_ready = 0;
    int            os_rh = 0;
    logic [31:0]   os_rpc = '0;
    int            resp_lat = 0;

    // what the DUT actually produced
    logic [31:0] req_log [$];
    logic [31:0] dlv_pc [$];
    logic [31:0] dlv_inst [$];
    int          dlv_hart [$];

    function automatic int pick(input int rr, input logic [NH-1:0] en);
        for (int i = 0; i < NH; i++) if (en[(rr + i) % NH]) return (rr + i) % NH;
        return -1;
    endfunction

    task automatic latch_prev();
        p_en     = hart_en;
        p_gnt    = ifc.imem_gnt;
        p_rvalid = ifc.imem_rvalid;
        p_rdata  = ifc.imem_rdata;
        p_ready  = ifc.inst_ready;
        p_redir  = ifc.redirect_valid;
        p_rh     = int'(ifc.redirect_hart);
        p_rpc    = ifc.redirect_pc;
`ifdef IFETCH_ERR_EN
        p_err    = ifc.imem_err;
`else
        p_err    = 1'b0;
`endif
    endtask

    task automatic cycle();
        bit was_idle;
        int h;
        @(negedge clk);
        was_idle = m_idle;
        if (p_redir) begin
            mpc[p_rh] = p_rpc & 32'hFFFF_FFFC;
            if (txn_act && txn_hart == p_rh) txn_kill = 1;
        end
        if (hold_act) begin
            if (p_redir && p_rh == hold_hart) begin
                hold_act = 0; mrr = (hold_hart + 1) % NH; m_idle = 1;
            end else if (p_ready) begin
                mpc[hold_hart] = mpc[hold_hart] + 32'd4;
                hold_act = 0; mrr = (hold_hart + 1) % NH; m_idle = 1;
            end
        end
        if (txn_act && txn_gnt && p_rvalid) begin
            txn_act = 0;
            if (txn_kill) begin
                mrr = (txn_hart + 1) % NH; m_idle = 1;
            end else begin
                hold_act   = 1;
                hold_hart  = txn_hart;
                hold_pc    = txn_addr;
                hold_inst  = p_err ? 32'h0 : p_rdata;
                hold_fault = p_err;
                dlv_pc.push_back(ifc.inst_pc);
                dlv_inst.push_back(ifc.inst);
                dlv_hart.push_back(int'(ifc.inst_hart));
            end
        end
        if (txn_act && !txn_gnt && p_gnt) txn_gnt = 1;
        if (was_idle) begin
            h = pick(mrr, p_en);
            if (h >= 0) begin
                txn_act = 1; txn_gnt = 0; txn_kill = 0;
                txn_hart = h; txn_addr = mpc[h]; m_idle = 0;
            end
        end
        if (ifc.imem_req && !q_req) req_log.push_back(ifc.imem_addr);

        chk("imem_req", 32'(ifc.imem_req), 32'(txn_act && !txn_gnt));
        if (txn_act && !txn_gnt) chk("imem_addr", ifc.imem_addr, txn_addr);
        chk("inst_valid", 32'(ifc.inst_valid), 32'(hold_act));
        if (hold_act) begin
            chk("inst", ifc.inst, hold_inst);
            chk("inst_pc", ifc.inst_pc, hold_pc);
            chk("inst_hart", 32'(ifc.inst_hart), 32'(hold_hart));
`ifdef IFETCH_ERR_EN
            chk("inst_fault", 32'(ifc.inst_fault), 32'(hold_fault));
`endif
        end
        q_req = ifc.imem_req;

        // memory responder
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = $urandom;
`ifdef IFETCH_ERR_EN
        ifc.imem_err    = err_on && ($urandom_range(0, 3) == 0);
`endif
        if (resp_lat > 0) begin
            resp_lat--;
            if (resp_lat == 0) begin
                ifc.imem_rvalid = 1'b1;
                if (fixed_data) ifc.imem_rdata = 32'h0050_0093;
            end
        end
        ifc.imem_gnt = ifc.imem_req && ($urandom_range(0, 1) == 1);
        if (ifc.imem_gnt) resp_lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 3));

        case (ready_mode)
            0:       ifc.inst_ready = 1'b1;
            1:       ifc.inst_ready = ($urandom_range(0, 2) != 0);
            default: ifc.inst_ready = 1'b0;
        endcase
        if (os_ready) begin ifc.inst_ready = 1'b1; os_ready = 0; end

        ifc.redirect_valid = 1'b0;
        ifc.redirect_hart  = 2'($urandom_range(0, NH - 1));
        ifc.redirect_pc    = $urandom;
        if (os_redir) begin
            ifc.redirect_valid = 1'b1;
            ifc.redirect_hart  = 2'(os_rh);
            ifc.redirect_pc    = os_rpc;
            os_redir = 0;
        end else if (rand_redir && $urandom_range(0, 5) == 0) begin
            ifc.redirect_valid = 1'b1;
            if ($urandom_range(0, 7) == 0) ifc.redirect_pc = 32'hFFFF_FFFF;
        end

        if (rand_en && $urandom_range(0, 19) == 0) want_en = NH'($urandom);
        hart_en = want_en;
        latch_prev();
    endtask

    task automatic run_dlv(input string name, input int n, input int budget);
        int target = dlv_pc.size() + n;
        int k = 0;
        while (dlv_pc.size() < target && k < budget) begin cycle(); k++; end
        chk(name, 32'(dlv_pc.size()), 32'(target));
    endtask

    task automatic run_idle(input string name, input int budget);
        int k = 0;
        while (!m_idle && k < budget) begin cycle(); k++; end
        chk(name, 32'(m_idle), 32'd1);
    endtask

    task automatic run_gnt(input string name, input int budget);
        int k = 0;
        while (!(txn_act && txn_gnt) && k < budget) begin cycle(); k++; end
        chk(name, 32'(txn_act && txn_gnt), 32'd1);
    endtask

    initial begin
        int rb, db;
        ifc.imem_gnt = 0; ifc.imem_rvalid = 0; ifc.imem_rdata = '0; ifc.inst_ready = 0;
        ifc.redirect_valid = 0; ifc.redirect_hart = '0; ifc.redirect_pc = '0;
`ifdef IFETCH_ERR_EN
        ifc.imem_err = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(ifc.imem_req), 32'd0);
        chk("rst_addr", ifc.imem_addr, 32'd0);
        chk("rst_valid", 32'(ifc.inst_valid), 32'd0);
        chk("rst_inst", ifc.inst, 32'd0);
        chk("rst_pc", ifc.inst_pc, 32'd0);
        chk("rst_hart", 32'(ifc.inst_hart), 32'd0);
`ifdef IFETCH_ERR_EN
        chk("rst_fault", 32'(ifc.inst_fault), 32'd0);
`endif
        for (int h = 0; h < NH; h++) mpc[h] = RST_PC;
        mrr = 0; m_idle = 1; txn_act = 0; txn_gnt = 0; txn_kill = 0; hold_act = 0; q_req = 0;
        want_en = 4'b1111; hart_en = want_en; ifc.inst_ready = 1;
        latch_prev();
        rst_n = 1'b1;

        // all harts enabled: round robin 0,1,2,3,0 starting from RESET_PC
        run_dlv("p1_timeout", 5, 200);
        chk("p1_hart0", 32'(dlv_hart[0]), 32'd0);
        chk("p1_hart1", 32'(dlv_hart[1]), 32'd1);
        chk("p1_hart2", 32'(dlv_hart[2]), 32'd2);
        chk("p1_hart3", 32'(dlv_hart[3]), 32'd3);
        chk("p1_hart4", 32'(dlv_hart[4]), 32'd0);
        chk("p1_pc3", dlv_pc[3], 32'h100);
        chk("p1_pc4", dlv_pc[4], 32'h104);
        chk("p1_inst", dlv_inst[0], 32'h0050_0093);

        // single hart from PC 0: 0x0, 0x4, 0x8
        want_en = '0;
        run_idle("p2_idle", 50);
        os_redir = 1; os_rh = 0; os_rpc = 32'h0;
        cycle();
        want_en = 4'b0001;
        rb = req_log.size(); db = dlv_pc.size();
        run_dlv("p2_timeout", 3, 100);
        chk("p2_req0", req_log[rb], 32'h0);
        chk("p2_req1", req_log[rb + 1], 32'h4);
        chk("p2_req2", req_log[rb + 2], 32'h8);
        chk("p2_pc2", dlv_pc[db + 2], 32'h8);
        chk("p2_hart2", 32'(dlv_hart[db + 2]), 32'd0);

        // back-pressure for 5 cycles on the 0xC fetch
        ready_mode = 2;
        run_dlv("p3_timeout", 1, 100);
        repeat (5) cycle();
        chk("p3_held_pc", ifc.inst_pc, 32'hC);
        chk("p3_model_pc", mpc[0], 32'hC);
        ready_mode = 0;
        rb = req_log.size();
        run_dlv("p3b_timeout", 1, 100);
        chk("p3_next_req", req_log[rb], 32'h10);

        // redirect while the 0x14 fetch is in WAIT
        fix_lat = 3;
        rb = req_log.size(); db = dlv_pc.size();
        run_gnt("p4_gnt", 100);
        os_redir = 1; os_rh = 0; os_rpc = 32'h203;
        run_dlv("p4_timeout", 1, 100);
        chk("p4_killed_req", req_log[rb], 32'h14);
        chk("p4_refetch", req_log[rb + 1], 32'h200);
        chk("p4_dlv_pc", dlv_pc[db], 32'h200);
        fix_lat = 0;

        // redirect coincident with handshake: no +4
        ready_mode = 2;
        run_dlv("p5_timeout", 1, 100);
        os_redir = 1; os_rh = 0; os_rpc = 32'h40; os_ready = 1;
        cycle();
        ready_mode = 0;
        rb = req_log.size();
        run_dlv("p5b_timeout", 1, 100);
        chk("p5_req", req_log[rb], 32'h40);

        // PC wrap from 0xFFFFFFFC
        want_en = '0;
        run_idle("p6_idle", 50);
        os_redir = 1; os_rh = 0; os_rpc = 32'hFFFF_FFFF;
        cycle();
        want_en = 4'b0001;
        rb = req_log.size(); db = dlv_pc.size();
        run_dlv("p6_timeout", 2, 100);
        chk("p6_top", dlv_pc[db], 32'hFFFF_FFFC);
        chk("p6_wrap_req", req_log[rb + 1], 32'h0);
        chk("p6_wrap_pc", dlv_pc[db + 1], 32'h0);

        // randomized traffic
        want_en = 4'b1111; ready_mode = 1; rand_redir = 1; rand_en = 1;
        fixed_data = 0; err_on = 1;
        db = dlv_pc.size();
        repeat (3000) cycle();
        chk("rand_progress", 32'(dlv_pc.size() > db + 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end
endmodule
